// File: rtl/mem_arbiter.sv
// Shares one memory port between an instruction-fetch port and a data port.
// Data normally wins; a waiting fetch is forced through after STARVE data grants.
module mem_arbiter #(
    parameter int STARVE  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        stall_f,
    output logic        stall_m,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [3:0]  STARVE_LIM = 4'(STARVE);
    localparam logic [7:0]  BUSY_LAST  = 8'(TIMEOUT - 1);
    localparam logic [31:0] ABORT_WORD = 32'hDEAD_BEEF;

    state_t      state_q, state_d;
    logic        m_req_q, m_req_d;
    logic        m_we_q, m_we_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        i_ready_q, i_ready_d;
    logic        d_ready_q, d_ready_d;
    logic        err_q, err_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic [7:0]  busy_cnt_q, busy_cnt_d;
    logic        starve_at_lim_s;

    assign starve_at_lim_s = (starve_cnt_q == STARVE_LIM);

    // Next-state and output computation for the arbitration FSM
    always_comb begin
        state_d      = state_q;
        m_req_d      = m_req_q;
        m_we_d       = m_we_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_ready_d    = 1'b0;
        d_ready_d    = 1'b0;
        err_d        = err_q;
        starve_cnt_d = starve_cnt_q;
        busy_cnt_d   = busy_cnt_q;
        case (state_q)
            IDLE: begin
                if (d_req && !(i_req && starve_at_lim_s)) begin
                    state_d    = BUSY_D;
                    m_req_d    = 1'b1;
                    m_we_d     = d_we;
                    m_addr_d   = d_addr;
                    m_wdata_d  = d_wdata;
                    busy_cnt_d = 8'd0;
                    if (i_req) begin
                        starve_cnt_d = starve_at_lim_s ? starve_cnt_q : starve_cnt_q + 4'd1;
                    end else begin
                        starve_cnt_d = 4'd0;
                    end
                end else if (i_req) begin
                    state_d      = BUSY_I;
                    m_req_d      = 1'b1;
                    m_we_d       = 1'b0;
                    m_addr_d     = i_addr;
                    m_wdata_d    = 32'd0;
                    busy_cnt_d   = 8'd0;
                    starve_cnt_d = 4'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY_I, BUSY_D: begin
                // An ack arriving on the last allowed cycle still completes normally
                if (m_ack) begin
                    state_d = RESP;
                    m_req_d = 1'b0;
                    if (state_q == BUSY_I) begin
                        i_rdata_d = m_rdata;
                        i_ready_d = 1'b1;
                    end else begin
                        d_ready_d = 1'b1;
                        d_rdata_d = m_we_q ? d_rdata_q : m_rdata;
                    end
                end else if (busy_cnt_q == BUSY_LAST) begin
                    state_d = RESP;
                    m_req_d = 1'b0;
                    err_d   = 1'b1;
                    if (state_q == BUSY_I) begin
                        i_rdata_d = ABORT_WORD;
                        i_ready_d = 1'b1;
                    end else begin
                        d_ready_d = 1'b1;
                        d_rdata_d = m_we_q ? d_rdata_q : ABORT_WORD;
                    end
                end else begin
                    busy_cnt_d = busy_cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            m_req_q      <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= 32'd0;
            m_wdata_q    <= 32'd0;
            i_rdata_q    <= 32'd0;
            d_rdata_q    <= 32'd0;
            i_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
            err_q        <= 1'b0;
            starve_cnt_q <= 4'd0;
            busy_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            m_req_q      <= m_req_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_ready_q    <= i_ready_d;
            d_ready_q    <= d_ready_d;
            err_q        <= err_d;
            starve_cnt_q <= starve_cnt_d;
            busy_cnt_q   <= busy_cnt_d;
        end
    end

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_ready = i_ready_q;
    assign d_ready = d_ready_q;
    assign err     = err_q;
    assign stall_f = i_req & ~i_ready_q;
    assign stall_m = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requesters push expected responses, a
// memory model answers m_req, and a monitor pops and compares on each ready.
module tb_mem_arbiter;
    localparam int STARVE  = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we, m_ack;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic        i_ready, d_ready, m_req, m_we, stall_f, stall_m, err;

    mem_arbiter #(.STARVE(STARVE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack),
        .stall_f(stall_f), .stall_m(stall_m), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [31:0] data;
        bit          to;
    } exp_t;

    exp_t        i_exp[$];
    exp_t        d_exp[$];
    logic [31:0] exp_mem[logic [31:0]];
    logic [31:0] mem[logic [31:0]];
    bit          grant_log[$];
    int          total = 0;
    int          bad = 0;
    bit          err_exp = 1'b0;
    logic [31:0] last_d = 32'd0;
    int          streak = 0;
    int          mode = 0;      // 0 random delay, 1 never ack, 2 ack on 16th cycle, 3 immediate
    bit          force_ack = 1'b0;
    bit          expect_timeout = 1'b0;
    bit          mon_en = 1'b0;
    bit          prev_ir = 1'b0;
    bit          prev_dr = 1'b0;
    bit          in_acc = 1'b0;
    bit          acked = 1'b0;
    bit          is_d;
    int          delay = 0;
    int          blen = 0;
    logic        a_we;
    logic [31:0] a_addr, a_wd;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1F2E};
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (exp_mem.exists(a)) return exp_mem[a];
        return init_word(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_m_req"}, 32'(m_req), 32'd0);
        chk({tag, "_m_we"}, 32'(m_we), 32'd0);
        chk({tag, "_m_addr"}, m_addr, 32'd0);
        chk({tag, "_m_wdata"}, m_wdata, 32'd0);
        chk({tag, "_i_rdata"}, i_rdata, 32'd0);
        chk({tag, "_d_rdata"}, d_rdata, 32'd0);
        chk({tag, "_i_ready"}, 32'(i_ready), 32'd0);
        chk({tag, "_d_ready"}, 32'(d_ready), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic clear_model();
        i_exp.delete();
        d_exp.delete();
        err_exp = 1'b0;
        last_d  = 32'd0;
        streak  = 0;
        prev_ir = 1'b0;
        prev_dr = 1'b0;
    endtask

    // Called at negedge+1; returns at negedge+1 after the ready pulse.
    task automatic fetch_req(input logic [31:0] a);
        exp_t e;
        bit   seen;
        e.we = 1'b0; e.to = 1'b0; e.data = model_rd(a);
        i_exp.push_back(e);
        i_addr = a;
        i_req  = 1'b1;
        seen   = 1'b0;
        for (int k = 0; k < 64 && !seen; k++) begin
            @(negedge clk);
            seen = i_ready;
        end
        chk("i_ready_seen", 32'(seen), 32'd1);
        #1;
        i_req = 1'b0;
    endtask

    task automatic data_req(input bit we, input logic [31:0] a, input logic [31:0] wd, input bit to);
        exp_t e;
        bit   seen;
        e.we = we; e.to = to;
        e.data = to ? 32'hDEAD_BEEF : (we ? 32'd0 : model_rd(a));
        if (we && !to) exp_mem[a] = wd;
        d_exp.push_back(e);
        d_we = we; d_addr = a; d_wdata = wd;
        d_req = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < 64 && !seen; k++) begin
            @(negedge clk);
            seen = d_ready;
        end
        chk("d_ready_seen", 32'(seen), 32'd1);
        #1;
        d_req = 1'b0;
    endtask

    // Monitor: compares responses against the scoreboard on every falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("stall_f", 32'(stall_f), 32'(i_req & ~i_ready));
                chk("stall_m", 32'(stall_m), 32'(d_req & ~d_ready));
                if (i_ready) begin
                    chk("i_ready_width", 32'(prev_ir), 32'd0);
                    if (i_exp.size() == 0) begin
                        chk("i_ready_unexpected", 32'(i_ready), 32'd0);
                    end else begin
                        e = i_exp.pop_front();
                        if (e.to) err_exp = 1'b1;
                        chk("i_rdata", i_rdata, e.data);
                    end
                end
                if (d_ready) begin
                    chk("d_ready_width", 32'(prev_dr), 32'd0);
                    if (d_exp.size() == 0) begin
                        chk("d_ready_unexpected", 32'(d_ready), 32'd0);
                    end else begin
                        e = d_exp.pop_front();
                        if (e.to) err_exp = 1'b1;
                        if (e.we) begin
                            chk("d_rdata_hold", d_rdata, last_d);
                        end else begin
                            chk("d_rdata", d_rdata, e.data);
                            last_d = e.data;
                        end
                    end
                end
                prev_ir = i_ready;
                prev_dr = d_ready;
                chk("err", 32'(err), 32'(err_exp));
            end
        end
    end

    // Memory model: checks each grant against the arbitration rule and answers it
    initial begin
        m_ack   = 1'b0;
        m_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            m_ack = 1'b0;
            if (force_ack) begin
                m_ack     = 1'b1;
                m_rdata   = 32'hBAD0_0ACC;
                force_ack = 1'b0;
            end else if (m_req && !acked) begin
                if (!in_acc) begin
                    in_acc = 1'b1;
                    blen   = 0;
                    a_we = m_we; a_addr = m_addr; a_wd = m_wdata;
                    is_d = d_req && !(i_req && streak == STARVE);
                    if (!is_d && !i_req) begin
                        chk("grant_without_request", 32'(m_req), 32'd0);
                    end else if (is_d) begin
                        streak = i_req ? ((streak < STARVE) ? streak + 1 : streak) : 0;
                        chk("grant_d_we", 32'(m_we), 32'(d_we));
                        chk("grant_d_addr", m_addr, d_addr);
                        chk("grant_d_wdata", m_wdata, d_wdata);
                    end else begin
                        streak = 0;
                        chk("grant_i_we", 32'(m_we), 32'd0);
                        chk("grant_i_addr", m_addr, i_addr);
                        chk("grant_i_wdata", m_wdata, 32'd0);
                    end
                    grant_log.push_back(d_req && (m_addr == d_addr));
                    delay = (mode == 2) ? 15 : ((mode == 3) ? 0 : $urandom_range(0, 3));
                end else begin
                    chk("m_addr_hold", m_addr, a_addr);
                    chk("m_we_hold", 32'(m_we), 32'(a_we));
                    chk("m_wdata_hold", m_wdata, a_wd);
                end
                blen++;
                if (mode != 1 && delay == 0) begin
                    m_ack = 1'b1;
                    if (a_we) begin
                        mem[a_addr] = a_wd;
                        m_rdata = $urandom;
                    end else begin
                        m_rdata = mem.exists(a_addr) ? mem[a_addr] : init_word(a_addr);
                    end
                    acked = 1'b1;
                end else if (delay > 0) begin
                    delay--;
                end
            end else if (!m_req) begin
                if (in_acc && !acked && expect_timeout) chk("busy_len", 32'(blen), 32'(TIMEOUT));
                in_acc = 1'b0;
                acked  = 1'b0;
            end
        end
    end

    initial begin
        bit pat[6];
        reset = 1'b0;
        i_req = 1'b0; i_addr = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;

        // Fetch only, ack on the first busy cycle
        mode = 3;
        exp_mem[32'h40] = 32'h2008_0005;
        mem[32'h40]     = 32'h2008_0005;
        @(negedge clk); #1;
        begin
            exp_t e;
            e.we = 1'b0; e.to = 1'b0; e.data = model_rd(32'h40);
            i_exp.push_back(e);
        end
        i_addr = 32'h40;
        i_req  = 1'b1;
        @(negedge clk);
        chk("f_m_req_c1", 32'(m_req), 32'd1);
        chk("f_m_we_c1", 32'(m_we), 32'd0);
        chk("f_i_ready_c1", 32'(i_ready), 32'd0);
        @(negedge clk);
        chk("f_i_ready_c2", 32'(i_ready), 32'd1);
        chk("f_i_rdata_c2", i_rdata, 32'h2008_0005);
        #1;
        i_req = 1'b0;
        @(negedge clk);
        chk("f_i_ready_c3", 32'(i_ready), 32'd0);
        chk("f_m_req_c3", 32'(m_req), 32'd0);
        #1;

        // Simultaneous requests: data first, then fetch
        mode = 0;
        grant_log.delete();
        fork
            fetch_req(32'h44);
            data_req(1'b1, 32'h80, 32'h1234, 1'b0);
        join
        chk("sim_grants", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() >= 2) begin
            chk("sim_first_data", 32'(grant_log[0]), 32'd1);
            chk("sim_second_fetch", 32'(grant_log[1]), 32'd0);
        end
        data_req(1'b0, 32'h80, $urandom, 1'b0);

        // Starvation guard with back-to-back data requests
        mode = 3;
        grant_log.delete();
        pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        fork
            fetch_req(32'h100);
            for (int n = 0; n < 6; n++) data_req(1'b0, 32'h0002_0000 + 32'(n * 4), $urandom, 1'b0);
        join
        chk("starve_grants", 32'(grant_log.size()), 32'd7);
        for (int k = 0; k < 6 && k < grant_log.size(); k++) chk("starve_order", 32'(grant_log[k]), 32'(pat[k]));

        // Randomized mix on both ports
        mode = 0;
        fork
            for (int n = 0; n < 30; n++) begin
                repeat ($urandom_range(0, 3)) begin @(negedge clk); #1; end
                fetch_req({16'd0, 14'($urandom_range(0, 16383)), 2'b00});
            end
            for (int n = 0; n < 30; n++) begin
                repeat ($urandom_range(0, 3)) begin @(negedge clk); #1; end
                data_req(1'($urandom_range(0, 1)),
                         32'h0001_0000 + {27'd0, 3'($urandom_range(0, 7)), 2'b00},
                         $urandom, 1'b0);
            end
        join

        // Ack coincident with the timeout cycle: normal completion
        mode = 2;
        data_req(1'b0, 32'h0001_0004, $urandom, 1'b0);

        // Timeout on a data read, then err must stay set
        mode = 1;
        expect_timeout = 1'b1;
        data_req(1'b0, 32'h0001_0008, $urandom, 1'b1);
        expect_timeout = 1'b0;
        mode = 0;
        fetch_req(32'h300);
        repeat (4) begin @(negedge clk); #1; end

        // Reset in the second fetch busy cycle, late ack afterwards
        mode = 1;
        i_addr = 32'h200;
        i_req  = 1'b1;
        @(negedge clk);
        chk("rst_m_req_busy1", 32'(m_req), 32'd1);
        @(negedge clk); #1;
        reset = 1'b0;
        i_req = 1'b0;
        force_ack = 1'b1;
        clear_model();
        @(posedge clk); #2;
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        @(negedge clk);
        check_all_zero("lateack");
        #1;
        mode = 0;
        fetch_req(32'h204);

        repeat (3) @(negedge clk);
        chk("i_exp_left", 32'(i_exp.size()), 32'd0);
        chk("d_exp_left", 32'(d_exp.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule
